axi4_lite_write_slave_responder: RTL and testbench

Synthesizable AXI4-Lite write-channel slave that serves as the DUT-side endpoint for the write slave agent's bus. It accepts one write at a time on AW/W, inserts programmable AWREADY/WREADY/BVALID delays, and decodes the address against a legal window. It commits byte-strobed data into a small register file and returns BRESP. A debug read port exposes the register file so the bench can check stored contents directly.

---
 rtl/axi4_lite_write_slave_responder.sv | 200 ++++++++++++++++++++
 tb/tb_axi4_lite_write_slave_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_write_slave_responder.sv
// AXI4-Lite write slave endpoint: one transaction at a time, programmable
// AW/W/B delays, address window decode and a byte-strobed register file.
module axi4_lite_write_slave_responder #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       DELAY_WIDTH   = 5,
    parameter int                       MEM_DEPTH     = 16,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = 32'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = 32'h0000_0FFF,
    parameter bit                       SECURE_ONLY   = 1'b0
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ADDRESS_WIDTH-1:0]     awaddr,
    input  logic [2:0]                   awprot,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [DELAY_WIDTH-1:0]       cfgAwreadyDelay,
    input  logic [DELAY_WIDTH-1:0]       cfgWreadyDelay,
    input  logic [DELAY_WIDTH-1:0]       cfgBvalidDelay,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbgIndex,
    output logic [DATA_WIDTH-1:0]        dbgData
);

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT  = $clog2(STRB_WIDTH);
    localparam int INDEX_WIDTH = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LIMIT = ADDRESS_WIDTH'(MEM_DEPTH);
    localparam logic [DELAY_WIDTH-1:0]   DELAY_ONE   = DELAY_WIDTH'(1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_ACCEPT, ST_EXEC, ST_BWAIT, ST_BRESP} state_t;

    state_t state, state_next;

    logic                     aw_captured, aw_pending;
    logic [DELAY_WIDTH-1:0]   aw_count;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic                     aw_nonsecure_q;
    logic                     w_captured, w_pending;
    logic [DELAY_WIDTH-1:0]   w_count;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_WIDTH-1:0]    w_strb_q;
    logic [DELAY_WIDTH-1:0]   b_count;

    logic                     aw_done, w_done;
    logic                     below_min;
    logic [ADDRESS_WIDTH-1:0] offset, word_index;
    logic [INDEX_WIDTH-1:0]   mem_index;
    logic [1:0]               resp_code;
    logic                     write_enable;
    logic                     unused_prot;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign unused_prot = ^{awprot[2], awprot[0]};
    assign aw_done     = aw_captured || (awready && awvalid);
    assign w_done      = w_captured || (wready && wvalid);
    assign dbgData     = mem[dbgIndex];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= ST_ACCEPT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ACCEPT: if (aw_done && w_done) state_next = ST_EXEC;
            ST_EXEC:   state_next = (cfgBvalidDelay == '0) ? ST_BRESP : ST_BWAIT;
            ST_BWAIT:  if (b_count == DELAY_ONE) state_next = ST_BRESP;
            ST_BRESP:  if (bvalid && bready) state_next = ST_ACCEPT;
            default:   state_next = ST_ACCEPT;
        endcase
    end

    // Each channel: wait out its sampled delay, pulse ready for one cycle, then stay captured.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            awready        <= 1'b0;
            aw_pending     <= 1'b0;
            aw_captured    <= 1'b0;
            aw_count       <= '0;
            aw_addr_q      <= '0;
            aw_nonsecure_q <= 1'b0;
        end else if (state != ST_ACCEPT) begin
            awready     <= 1'b0;
            aw_pending  <= 1'b0;
            aw_captured <= 1'b0;
        end else if (awready) begin
            awready <= 1'b0;
            if (awvalid) begin
                aw_captured    <= 1'b1;
                aw_addr_q      <= awaddr;
                aw_nonsecure_q <= awprot[1];
            end
        end else if (aw_pending) begin
            if (aw_count == DELAY_ONE) begin
                awready    <= 1'b1;
                aw_pending <= 1'b0;
            end else begin
                aw_count <= aw_count - DELAY_ONE;
            end
        end else if (!aw_captured && awvalid) begin
            if (cfgAwreadyDelay == '0) begin
                awready <= 1'b1;
            end else begin
                aw_pending <= 1'b1;
                aw_count   <= cfgAwreadyDelay;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wready     <= 1'b0;
            w_pending  <= 1'b0;
            w_captured <= 1'b0;
            w_count    <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else if (state != ST_ACCEPT) begin
            wready     <= 1'b0;
            w_pending  <= 1'b0;
            w_captured <= 1'b0;
        end else if (wready) begin
            wready <= 1'b0;
            if (wvalid) begin
                w_captured <= 1'b1;
                w_data_q   <= wdata;
                w_strb_q   <= wstrb;
            end
        end else if (w_pending) begin
            if (w_count == DELAY_ONE) begin
                wready    <= 1'b1;
                w_pending <= 1'b0;
            end else begin
                w_count <= w_count - DELAY_ONE;
            end
        end else if (!w_captured && wvalid) begin
            if (cfgWreadyDelay == '0) begin
                wready <= 1'b1;
            end else begin
                w_pending <= 1'b1;
                w_count   <= cfgWreadyDelay;
            end
        end
    end

    // The subtraction borrow doubles as the below-window test.
    always_comb begin
        {below_min, offset} = {1'b0, aw_addr_q} - {1'b0, MIN_ADDRESS};
        word_index   = offset >> BYTE_SHIFT;
        mem_index    = word_index[INDEX_WIDTH-1:0];
        resp_code    = RESP_OKAY;
        write_enable = 1'b0;
        if (below_min || (aw_addr_q > MAX_ADDRESS)) begin
            resp_code = RESP_DECERR;
        end else if (SECURE_ONLY && aw_nonsecure_q) begin
            resp_code = RESP_SLVERR;
        end else if (word_index >= DEPTH_LIMIT) begin
            resp_code = RESP_SLVERR;
        end else begin
            write_enable = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            b_count <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            bvalid <= (state_next == ST_BRESP);
            if (state == ST_EXEC) begin
                bresp   <= resp_code;
                b_count <= cfgBvalidDelay;
                if (write_enable) begin
                    for (int i = 0; i < STRB_WIDTH; i++) begin
                        if (w_strb_q[i]) mem[mem_index][8*i +: 8] <= w_data_q[8*i +: 8];
                    end
                end
            end else if (state == ST_BWAIT) begin
                b_count <= b_count - DELAY_ONE;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_write_slave_responder.sv
// Directed bench for the AXI4-Lite write responder: a queue of expected
// BRESP codes is filled by the stimulus and drained by a B-channel monitor.
module tb_axi4_lite_write_slave_responder;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  cfgAwreadyDelay;
    logic [4:0]  cfgWreadyDelay;
    logic [4:0]  cfgBvalidDelay;
    logic [3:0]  dbgIndex;
    logic [31:0] dbgData;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int aw_abs     = 0;
    int b_abs      = 0;
    int prev_b     = 0;

    logic [1:0] sb[$];

    logic [1:0] held_resp;
    bit         holding   = 1'b0;
    bit         stable_ok = 1'b1;

    axi4_lite_write_slave_responder #(
        .SECURE_ONLY(1'b1)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .awaddr(awaddr),
        .awprot(awprot),
        .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata),
        .wstrb(wstrb),
        .wvalid(wvalid),
        .wready(wready),
        .bresp(bresp),
        .bvalid(bvalid),
        .bready(bready),
        .cfgAwreadyDelay(cfgAwreadyDelay),
        .cfgWreadyDelay(cfgWreadyDelay),
        .cfgBvalidDelay(cfgBvalidDelay),
        .dbgIndex(dbgIndex),
        .dbgData(dbgData)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_mem(input logic [3:0] idx, input logic [31:0] expected);
        dbgIndex = idx;
        #1;
        check_output($sformatf("mem[%0d]", idx), dbgData, expected);
    endtask

    // B-channel monitor: pops an expected code at every B handshake and checks hold stability.
    always @(negedge aclk) begin
        if (areset) begin
            holding = 1'b0;
        end else if (bvalid) begin
            if (!holding) begin
                holding   = 1'b1;
                held_resp = bresp;
                stable_ok = 1'b1;
            end else if (bresp != held_resp) begin
                stable_ok = 1'b0;
            end
            if (bready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_bresp: actual bvalid with bresp 0x%0h, required no response", bresp);
                end else begin
                    check_output("bresp", bresp, sb.pop_front());
                    check_output("bresp_stable", stable_ok, 1);
                end
                holding = 1'b0;
            end
        end
    end

    // One full write; caller is positioned just after a rising edge, which is cycle 0.
    task automatic apply_stimulus(
        input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
        input logic [3:0] strb, input int aw_lag, input int w_lag, input int hold,
        input bit keep_aw, input logic [1:0] exp_resp,
        input int exp_aw, input int exp_w, input int exp_b);
        int aw_cycle = -1;
        int w_cycle  = -1;
        int b_cycle  = -1;
        int extra    = 0;
        bit aw_got   = 1'b0;
        bit w_got    = 1'b0;
        bit b_done   = 1'b0;
        sb.push_back(exp_resp);
        awaddr = addr;
        awprot = prot;
        wdata  = data;
        wstrb  = strb;
        for (int c = 0; c < 200 && !b_done; c++) begin
            awvalid = (c >= aw_lag) && (!aw_got || keep_aw);
            wvalid  = (c >= w_lag) && !w_got;
            bready  = (hold == 0) || (b_cycle >= 0 && (c - b_cycle) >= hold);
            @(negedge aclk);
            if (awready && aw_got) extra++;
            if (wready && w_got) extra++;
            if (awready && awvalid && !aw_got) begin
                aw_got   = 1'b1;
                aw_cycle = c;
                aw_abs   = cyc;
            end
            if (wready && wvalid && !w_got) begin
                w_got   = 1'b1;
                w_cycle = c;
            end
            if (bvalid && b_cycle < 0) begin
                b_cycle = c;
                b_abs   = cyc;
            end
            if (bvalid && bready) b_done = 1'b1;
            @(posedge aclk);
            #1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        if (!b_done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL b_handshake_timeout: actual none in 200 cycles, required a response");
        end
        check_output("awready_cycle", aw_cycle, exp_aw);
        check_output("wready_cycle", w_cycle, exp_w);
        check_output("bvalid_cycle", b_cycle, exp_b);
        check_output("spurious_ready", extra, 0);
    endtask

    initial begin
        areset          = 1'b1;
        awaddr          = '0;
        awprot          = '0;
        awvalid         = 1'b0;
        wdata           = '0;
        wstrb           = '0;
        wvalid          = 1'b0;
        bready          = 1'b0;
        cfgAwreadyDelay = '0;
        cfgWreadyDelay  = '0;
        cfgBvalidDelay  = '0;
        dbgIndex        = '0;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;

        check_output("reset_awready", awready, 0);
        check_output("reset_wready", wready, 0);
        check_output("reset_bvalid", bvalid, 0);
        check_output("reset_bresp", bresp, 0);
        check_mem(4'd2, 32'h0);

        $display("[TB] basic write");
        apply_stimulus(32'h8, 3'b000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 2'b00, 1, 1, 3);
        prev_b = b_abs;
        check_mem(4'd2, 32'hDEADBEEF);

        $display("[TB] back-to-back and partial strobes");
        apply_stimulus(32'h0, 3'b000, 32'h11223344, 4'hF, 0, 0, 0, 1'b0, 2'b00, 1, 1, 3);
        check_output("b_to_next_awready_gap", aw_abs - prev_b, 2);
        apply_stimulus(32'h0, 3'b000, 32'hAABBCCDD, 4'h5, 0, 0, 0, 1'b0, 2'b00, 1, 1, 3);
        check_mem(4'd0, 32'h11BB33DD);

        $display("[TB] decode errors");
        apply_stimulus(32'h1000, 3'b000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b0, 2'b11, 1, 1, 3);
        apply_stimulus(32'h40, 3'b000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1'b0, 2'b10, 1, 1, 3);
        apply_stimulus(32'h8, 3'b010, 32'h00000000, 4'hF, 0, 0, 0, 1'b0, 2'b10, 1, 1, 3);
        check_mem(4'd0, 32'h11BB33DD);
        check_mem(4'd2, 32'hDEADBEEF);

        $display("[TB] programmed delays");
        cfgAwreadyDelay = 5'd3;
        cfgWreadyDelay  = 5'd7;
        cfgBvalidDelay  = 5'd2;
        apply_stimulus(32'hC, 3'b000, 32'h12345678, 4'hF, 0, 0, 0, 1'b0, 2'b00, 4, 8, 12);
        cfgAwreadyDelay = '0;
        cfgWreadyDelay  = '0;
        cfgBvalidDelay  = '0;
        check_mem(4'd3, 32'h12345678);

        $display("[TB] skewed arrival and backpressure");
        apply_stimulus(32'h10, 3'b000, 32'h0BADCAFE, 4'hF, 4, 0, 0, 1'b0, 2'b00, 5, 1, 7);
        check_mem(4'd4, 32'h0BADCAFE);
        apply_stimulus(32'h3C, 3'b000, 32'hCAFEF00D, 4'hF, 5, 0, 10, 1'b1, 2'b00, 6, 1, 8);
        check_mem(4'd15, 32'hCAFEF00D);

        $display("[TB] reset during BWAIT");
        cfgBvalidDelay = 5'd10;
        awaddr  = 32'h14;
        awprot  = 3'b000;
        wdata   = 32'h77777777;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check_mem(4'd5, 32'h77777777);
        areset = 1'b1;
        #1;
        check_output("midreset_awready", awready, 0);
        check_output("midreset_wready", wready, 0);
        check_output("midreset_bvalid", bvalid, 0);
        check_output("midreset_mem5", dbgData, 0);
        check_mem(4'd2, 32'h0);
        @(posedge aclk);
        #1;
        areset         = 1'b0;
        cfgBvalidDelay = '0;
        repeat (14) @(posedge aclk);
        #1;
        bready = 1'b0;

        $display("[TB] write after reset");
        apply_stimulus(32'h4, 3'b000, 32'h5A5A5A5A, 4'hF, 0, 0, 0, 1'b0, 2'b00, 1, 1, 3);
        check_mem(4'd1, 32'h5A5A5A5A);
        check_mem(4'd15, 32'h0);

        repeat (3) @(posedge aclk);
        #1;
        check_output("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
